// File: rtl/fc_pkg.sv
// Shared constants, FSM state type and output saturation for the FC1 stage.
package fc_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int LANES       = 32;
    localparam int IN_WORDS    = 32;
    localparam int OUT_NEURONS = 64;
    localparam int FRAC_BITS   = 8;
    localparam int ACC_WIDTH   = 40;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} fc_state_t;

    // Clamp to signed 16 bits; with relu set the floor moves to 0.
    function automatic logic [DATA_WIDTH-1:0] sat16(input logic signed [ACC_WIDTH-1:0] v,
                                                    input logic relu);
        logic signed [ACC_WIDTH-1:0] hi;
        logic signed [ACC_WIDTH-1:0] lo;
        hi = 40'sd32767;
        lo = relu ? 40'sd0 : -40'sd32768;
        if (v > hi)      return hi[DATA_WIDTH-1:0];
        else if (v < lo) return lo[DATA_WIDTH-1:0];
        else             return v[DATA_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/fc1_engine_if.sv
// Read ports (flatten BRAM, weight ROM, bias ROM), result stream and control of fc1_engine.
interface fc1_engine_if;
    import fc_pkg::*;

    logic                          start;
    logic                          fc1_en;
    logic [4:0]                    fcin_addr;
    logic [DATA_WIDTH*LANES-1:0]   fcin_data;
    logic                          w_en;
    logic [10:0]                   w_addr;
    logic [DATA_WIDTH*LANES-1:0]   w_data;
    logic [5:0]                    bias_addr;
    logic [DATA_WIDTH-1:0]         bias_data;
    logic                          out_valid;
    logic [5:0]                    out_idx;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          busy;
    logic                          done;

    modport slave (
        input  start, fcin_data, w_data, bias_data,
        output fc1_en, fcin_addr, w_en, w_addr, bias_addr,
               out_valid, out_idx, out_data, busy, done
    );

    modport master (
        output start, fcin_data, w_data, bias_data,
        input  fc1_en, fcin_addr, w_en, w_addr, bias_addr,
               out_valid, out_idx, out_data, busy, done
    );
endinterface

// File: rtl/fc1_dot32.sv
// 32-lane signed Q8.8 dot product: full-width products, summed, one output register.
module fc1_dot32
    import fc_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]    a,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]    b,
    output logic signed [ACC_WIDTH-1:0]         dot
);
    logic signed [2*DATA_WIDTH-1:0] prod [LANES];
    logic signed [ACC_WIDTH-1:0]    sum;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign prod[i] = $signed(a[i]) * $signed(b[i]);
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++)
            sum = sum + $signed({{(ACC_WIDTH-2*DATA_WIDTH){prod[i][2*DATA_WIDTH-1]}}, prod[i]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dot <= '0;
        else        dot <= sum;
    end
endmodule

// File: rtl/fc1_engine.sv
// FC1 layer: streams 32 input words per neuron, accumulates, adds bias, saturates.
// Optional FC1_RELU_EN clamps negative results to zero.
module fc1_engine
    import fc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    fc1_engine_if.slave  bus
);
`ifdef FC1_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif
    // Stage 0 issue, 1 data return, 2 dot product, 3 accumulator.
    localparam int STAGES = 3;

    fc_state_t                   state;
    logic [STAGES:0]             vld_pipe;
    logic [STAGES-1:0]           first_pipe;
    logic [STAGES:0]             last_pipe;
    logic [4:0]                  fcin_addr;
    logic [10:0]                 w_addr;
    logic [10:0]                 nxt;
    logic [5:0]                  bias_addr;
    logic [DATA_WIDTH-1:0]       bias_q;
    logic signed [ACC_WIDTH-1:0] dot;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] fin;
    logic [5:0]                  out_cnt;
    logic                        out_valid;
    logic [5:0]                  out_idx;
    logic [DATA_WIDTH-1:0]       out_data;
    logic                        busy;
    logic                        done;

    fc1_dot32 u_dot (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (bus.fcin_data),
        .b     (bus.w_data),
        .dot   (dot)
    );

    assign nxt = w_addr + 11'd1;
    assign fin = (acc >>> FRAC_BITS) +
                 $signed({{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vld_pipe   <= '0;
            first_pipe <= '0;
            last_pipe  <= '0;
            fcin_addr  <= '0;
            w_addr     <= '0;
            bias_addr  <= '0;
            bias_q     <= '0;
            acc        <= '0;
            out_cnt    <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            vld_pipe[STAGES:1]   <= vld_pipe[STAGES-1:0];
            first_pipe[STAGES-1:1] <= first_pipe[STAGES-2:0];
            last_pipe[STAGES:1]  <= last_pipe[STAGES-1:0];
            out_valid <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: if (bus.start) begin
                    state         <= RUN;
                    busy          <= 1'b1;
                    vld_pipe[0]   <= 1'b1;
                    first_pipe[0] <= 1'b1;
                    last_pipe[0]  <= 1'b0;
                    fcin_addr     <= '0;
                    w_addr        <= '0;
                    out_cnt       <= '0;
                end
                RUN: begin
                    if (w_addr == '1) begin
                        state         <= FLUSH;
                        vld_pipe[0]   <= 1'b0;
                        first_pipe[0] <= 1'b0;
                        last_pipe[0]  <= 1'b0;
                    end else begin
                        w_addr        <= nxt;
                        fcin_addr     <= nxt[4:0];
                        first_pipe[0] <= (nxt[4:0] == 5'd0);
                        last_pipe[0]  <= (nxt[4:0] == 5'd31);
                        if (nxt[4:0] == 5'd31) bias_addr <= nxt[10:5];
                    end
                end
                FLUSH: if (out_valid && out_idx == 6'(OUT_NEURONS-1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            // Bias arrives with the neuron's last data word; hold it until finalisation.
            if (vld_pipe[1] && last_pipe[1]) bias_q <= bus.bias_data;
            if (vld_pipe[2]) acc <= first_pipe[2] ? dot : acc + dot;
            if (vld_pipe[3] && last_pipe[3]) begin
                out_valid <= 1'b1;
                out_idx   <= out_cnt;
                out_data  <= sat16(fin, RELU);
                out_cnt   <= out_cnt + 6'd1;
            end
        end
    end

    assign bus.fc1_en    = vld_pipe[0];
    assign bus.w_en      = vld_pipe[0];
    assign bus.fcin_addr = fcin_addr;
    assign bus.w_addr    = w_addr;
    assign bus.bias_addr = bias_addr;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = out_idx;
    assign bus.out_data  = out_data;
    assign bus.busy      = busy;
    assign bus.done      = done;
endmodule

// File: tb/tb_fc1_engine.sv
// Self-checking bench for fc1_engine: ROM models, output monitor and a dot-product reference.
module tb_fc1_engine;
    import fc_pkg::*;
`ifdef FC1_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fc1_engine_if bus();
    fc1_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [511:0] fcin_mem [32];
    logic [511:0] w_mem    [2048];
    logic [15:0]  bias_mem [64];
    logic [15:0]  expv     [64];

    always @(posedge clk) begin
        bus.fcin_data <= fcin_mem[bus.fcin_addr];
        bus.w_data    <= w_mem[bus.w_addr];
        bus.bias_data <= bias_mem[bus.bias_addr];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          oc_q[$];
    logic [5:0]  oi_q[$];
    logic [15:0] od_q[$];
    int          dn_q[$];
    logic        db_q[$];
    int          en_c[$];
    logic [10:0] en_w[$];
    logic [4:0]  en_f[$];
    int          en_mis = 0;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            oc_q.push_back(cyc); oi_q.push_back(bus.out_idx); od_q.push_back(bus.out_data);
        end
        if (bus.done) begin
            dn_q.push_back(cyc); db_q.push_back(bus.busy);
        end
        if (bus.fc1_en || bus.w_en) begin
            en_c.push_back(cyc); en_w.push_back(bus.w_addr); en_f.push_back(bus.fcin_addr);
            if (bus.fc1_en !== bus.w_en) en_mis++;
        end
    end

    // Reference: plain dot product over all 1024 inputs, floor shift, bias, clamp.
    function automatic void build_model();
        for (int n = 0; n < 64; n++) begin
            longint acc = 0;
            longint lo = RELU ? 0 : -32768;
            for (int w = 0; w < 32; w++)
                for (int i = 0; i < 32; i++)
                    acc += longint'($signed(fcin_mem[w][i*16 +: 16])) *
                           longint'($signed(w_mem[n*32+w][i*16 +: 16]));
            acc = acc >>> 8;
            acc += longint'($signed(bias_mem[n]));
            if (acc > 32767) acc = 32767;
            if (acc < lo) acc = lo;
            expv[n] = 16'(acc);
        end
    endfunction

    function automatic void fill_random();
        for (int w = 0; w < 32; w++)
            for (int i = 0; i < 32; i++) fcin_mem[w][i*16 +: 16] = 16'($urandom_range(0, 511) - 256);
        for (int a = 0; a < 2048; a++)
            for (int i = 0; i < 32; i++) w_mem[a][i*16 +: 16] = 16'($urandom_range(0, 511) - 256);
        for (int n = 0; n < 64; n++) bias_mem[n] = 16'($urandom_range(0, 4095) - 2048);
    endfunction

    function automatic void clear_mon();
        oc_q.delete(); oi_q.delete(); od_q.delete(); dn_q.delete(); db_q.delete();
        en_c.delete(); en_w.delete(); en_f.delete(); en_mis = 0;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1; t0 = cyc;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 2200 && dn_q.size() == 0; k++) @(posedge clk);
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        for (int w = 0; w < 32; w++) fcin_mem[w] = '0;
        for (int a = 0; a < 2048; a++) w_mem[a] = '0;
        for (int n = 0; n < 64; n++) bias_mem[n] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.fc1_en, bus.w_en, bus.out_valid, bus.busy, bus.done} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got %b want 00000",
                            {bus.fc1_en, bus.w_en, bus.out_valid, bus.busy, bus.done});
        end
        total++;
        if ({bus.fcin_addr, bus.w_addr, bus.bias_addr, bus.out_idx, bus.out_data} !== 44'h0) begin
            bad++; $display("FAIL reset_data got %h want 0",
                            {bus.fcin_addr, bus.w_addr, bus.bias_addr, bus.out_idx, bus.out_data});
        end
        total++;
        if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        for (int w = 0; w < 32; w++) for (int i = 0; i < 32; i++) fcin_mem[w][i*16 +: 16] = 16'h0100;
        for (int a = 0; a < 2048; a++) for (int i = 0; i < 32; i++) w_mem[a][i*16 +: 16] = 16'h0100;
        for (int n = 0; n < 64; n++) bias_mem[n] = 16'h0000;
        build_model(); clear_mon(); pulse_start(); wait_done();
        total++;
        if (oc_q.size() !== 64) begin bad++; $display("FAIL sat_count got %0d want 64", oc_q.size()); end
        for (int n = 0; n < oc_q.size() && n < 64; n++) begin
            total++;
            if (oi_q[n] !== 6'(n) || od_q[n] !== 16'h7FFF || od_q[n] !== expv[n] || oc_q[n] - t0 !== 32*n + 36) begin
                bad++; $display("FAIL sat_n%0d got idx=%0d data=%h cyc=%0d want idx=%0d data=7fff cyc=%0d",
                                n, oi_q[n], od_q[n], oc_q[n] - t0, n, 32*n + 36);
            end
        end
        total++;
        if (dn_q.size() !== 1 || dn_q[0] - t0 !== 2053 || db_q[0] !== 1'b0) begin
            bad++; $display("FAIL sat_done got count=%0d cyc=%0d want count=1 cyc=2053 busy=0",
                            dn_q.size(), dn_q.size() > 0 ? dn_q[0] - t0 : -1);
        end
    endtask

    task automatic test_lane0_bias();
        for (int w = 0; w < 32; w++) fcin_mem[w] = '0;
        fcin_mem[0][15:0] = 16'h0200;
        for (int a = 0; a < 2048; a++) begin w_mem[a] = '0; w_mem[a][15:0] = 16'h0080; end
        for (int n = 0; n < 64; n++) bias_mem[n] = 16'(n << 8);
        build_model(); clear_mon(); pulse_start(); wait_done();
        total++;
        if (oc_q.size() !== 64) begin bad++; $display("FAIL lane0_count got %0d want 64", oc_q.size()); end
        for (int n = 0; n < oc_q.size() && n < 64; n++) begin
            total++;
            if (od_q[n] !== 16'(256 + (n << 8)) || od_q[n] !== expv[n] || oi_q[n] !== 6'(n)) begin
                bad++; $display("FAIL lane0_n%0d got %h want %h", n, od_q[n], 16'(256 + (n << 8)));
            end
        end
        total++;
        if (oc_q.size() == 64 && (od_q[0] !== 16'h0100 || od_q[63] !== 16'h4000)) begin
            bad++; $display("FAIL lane0_ends got %h,%h want 0100,4000", od_q[0], od_q[63]);
        end
    endtask

    task automatic test_negative();
        logic [15:0] want;
        want = RELU ? 16'h0000 : 16'hE000;
        for (int w = 0; w < 32; w++) begin fcin_mem[w] = '0; fcin_mem[w][15:0] = 16'h0100; end
        for (int a = 0; a < 2048; a++) for (int i = 0; i < 32; i++) w_mem[a][i*16 +: 16] = 16'hFF00;
        for (int n = 0; n < 64; n++) bias_mem[n] = 16'h0000;
        clear_mon(); pulse_start(); wait_done();
        total++;
        if (oc_q.size() !== 64) begin bad++; $display("FAIL neg_count got %0d want 64", oc_q.size()); end
        for (int n = 0; n < oc_q.size() && n < 64; n++) begin
            total++;
            if (od_q[n] !== want) begin bad++; $display("FAIL neg_n%0d got %h want %h", n, od_q[n], want); end
        end
    endtask

    task automatic test_addr_trace();
        int err;
        fill_random(); build_model(); clear_mon(); pulse_start(); wait_done();
        err = 0;
        for (int k = 0; k < en_c.size(); k++)
            if (en_c[k] - t0 !== k + 1 || en_w[k] !== 11'(k) || en_f[k] !== 5'(k % 32)) err++;
        total++;
        if (en_c.size() !== 2048 || err !== 0 || en_mis !== 0) begin
            bad++; $display("FAIL trace got en_cycles=%0d errs=%0d en_mismatch=%0d want 2048,0,0",
                            en_c.size(), err, en_mis);
        end
        for (int n = 0; n < oc_q.size() && n < 64; n++) begin
            total++;
            if (od_q[n] !== expv[n]) begin bad++; $display("FAIL rand_n%0d got %h want %h", n, od_q[n], expv[n]); end
        end
    endtask

    task automatic test_restart_ignored();
        fill_random(); build_model(); clear_mon(); pulse_start();
        repeat (499) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done();
        total++;
        if (oc_q.size() !== 64 || dn_q.size() !== 1) begin
            bad++; $display("FAIL restart got outs=%0d dones=%0d want 64,1", oc_q.size(), dn_q.size());
        end
        for (int n = 0; n < oc_q.size() && n < 64; n++) begin
            total++;
            if (od_q[n] !== expv[n] || oc_q[n] - t0 !== 32*n + 36) begin
                bad++; $display("FAIL restart_n%0d got %h@%0d want %h@%0d", n, od_q[n], oc_q[n] - t0, expv[n], 32*n + 36);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_random(); build_model(); clear_mon(); pulse_start();
        repeat (999) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.fc1_en, bus.out_valid, bus.busy, bus.done, bus.out_data, bus.w_addr} !== 31'h0 || dut.state !== IDLE) begin
            bad++; $display("FAIL midreset got en=%b busy=%b data=%h waddr=%0d want all 0",
                            bus.fc1_en, bus.busy, bus.out_data, bus.w_addr);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        repeat (2200) @(posedge clk);
        total++;
        if (oc_q.size() !== 0 || dn_q.size() !== 0 || en_c.size() !== 0) begin
            bad++; $display("FAIL midreset_quiet got outs=%0d dones=%0d en=%0d want 0,0,0",
                            oc_q.size(), dn_q.size(), en_c.size());
        end
        fill_random(); build_model(); clear_mon(); pulse_start(); wait_done();
        total++;
        if (oc_q.size() !== 64 || dn_q.size() !== 1) begin
            bad++; $display("FAIL rerun got outs=%0d dones=%0d want 64,1", oc_q.size(), dn_q.size());
        end
        for (int n = 0; n < oc_q.size() && n < 64; n++) begin
            total++;
            if (od_q[n] !== expv[n] || oi_q[n] !== 6'(n)) begin
                bad++; $display("FAIL rerun_n%0d got %h want %h", n, od_q[n], expv[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_lane0_bias();
        test_negative();
        test_addr_trace();
        test_restart_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fc1_engine.md
Name: fc1_engine

Overview:
- First fully-connected layer stage. Sits directly downstream of the flatten unit.
- Reads the 1024-element flattened feature vector as 32 words of 32 lanes through the flatten unit's read port (fcin_addr/fcin_data, fc1_en).
- Multiplies each word by weights from an external weight ROM and accumulates per output neuron.
- Adds bias, optionally applies ReLU, saturates, and emits one 16-bit result per neuron.

Parameters:
- DATA_WIDTH, 16, width of activations, weights and bias (signed Q8.8).
- LANES, 32, elements per fcin word.
- IN_WORDS, 32, fcin words per input vector (fixed: fcin_addr is 5 bits).
- OUT_NEURONS, 64, number of output neurons.
- FRAC_BITS, 8, fractional bits of the fixed-point format.
- ACC_WIDTH, 40, accumulator width (signed).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse (driven from flatten_done); ignored while busy.
- fc1_en  out  1  read enable to the flatten second BRAM.
- fcin_addr  out  5  word address into the flatten BRAM.
- fcin_data  in  DATA_WIDTH*LANES  word read from the flatten BRAM; 1-cycle latency.
- w_en  out  1  weight ROM read enable.
- w_addr  out  11  weight ROM address = n*32+w.
- w_data  in  DATA_WIDTH*LANES  weight word; 1-cycle latency; lane i pairs with fcin lane i.
- bias_addr  out  6  bias ROM address = n.
- bias_data  in  DATA_WIDTH  bias; 1-cycle latency.
- out_valid  out  1  one-cycle pulse per neuron.
- out_idx  out  6  neuron index of out_data.
- out_data  out  DATA_WIDTH  neuron result, Q8.8.
- busy  out  1  high from first issue cycle until done.
- done  out  1  one-cycle pulse after the last neuron.

Behaviour:
- Reset: asynchronous, active-low. Every register clears and the FSM goes to IDLE. All outputs are 0.
- Reset mid-operation aborts the run; no partial out_valid or done follows.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN on start.
  - RUN -> FLUSH after issuing word 31 of neuron 63.
  - FLUSH -> IDLE when the last result is emitted; done pulses on that transition.
- Timing, with start sampled at cycle 0:
  - In cycle 1+32n+w, drive fcin_addr=w, w_addr=n*32+w, fc1_en=w_en=1. Issue is continuous; there are no bubbles between neurons.
  - bias_addr=n is driven in the w=31 cycle.
  - Pipeline: data returns at +1; fc1_dot32 registers the 32-lane sum at +2; the accumulator updates at +3; the output register updates at +4.
  - Neuron n therefore has out_valid=1 in cycle 32n+36. The last one is at cycle 2052. done=1 and busy=0 in cycle 2053.
- first/last tags travel with each issued word. "first" loads the accumulator instead of adding; "last" triggers finalisation.
- Arithmetic:
  - Each product is a signed 16x16 multiply giving 32 bits. The 32 products are summed at full width and sign-extended to ACC_WIDTH.
  - Finalise: shift the accumulator arithmetically right by FRAC_BITS (truncate toward -inf), add sign-extended bias, then saturate to [-32768, 32767].
- fc1_en and w_en are 0 outside RUN. A start pulse during RUN or FLUSH is ignored.
- out_idx and out_data hold their value between pulses.

Optional Feature:
- Macro FC1_RELU_EN.
- Defined: negative finalised values are output as 0, so the saturation range becomes [0, 32767].
- Undefined: signed saturation only.
- Timing is identical in both builds.

Decomposition:
- Package fc_pkg holds:
  - DATA_WIDTH, LANES, FRAC_BITS and ACC_WIDTH constants;
  - the FSM state typedef {IDLE, RUN, FLUSH};
  - a saturate-to-16-bit function.
- One sub-module, fc1_dot32: 32 signed multipliers plus an adder tree with a single output register, 1-cycle latency.
- Sequencing, accumulation and finalisation stay in fc1_engine.

Test Plan:
- All fcin lanes=0x0100 (1.0), all weights=0x0100, bias=0 -> every neuron outputs sum 1024.0, which saturates to 0x7FFF; out_valid at cycles 36, 68, ... 2052; done at 2053.
- fcin lane0 only=0x0200, w lane0 only=0x0080, bias[n]=n<<8 -> out_data=0x0100+(n<<8) for n<=126; check n=0 gives 0x0100 and n=63 gives 0x4000.
- Negative result (weights 0xFF00, fcin 0x0100, one lane/word set, bias 0) -> without FC1_RELU_EN out_data=0xE000 (-32.0); with it out_data=0x0000.
- Address trace -> fcin_addr cycles 0..31 repeating and w_addr 0..2047 contiguous; fc1_en/w_en high exactly cycles 1..2048.
- start pulsed again at cycle 500 -> ignored; exactly 64 out_valid pulses and one done.
- rst_n low at cycle 1000 for 2 cycles -> outputs 0 and FSM in IDLE; no out_valid/done afterward. A new start runs a clean full pass with correct results.
